// File: rtl/apb_slv_pkg.sv
// Shared types and widths for the APB completer register bank.
// Imported by the FSM top and the flop-array regfile.
package apb_slv_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int NUM_PSEL   = 4;
  localparam int ERR_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  typedef struct packed {
    logic [APB_ADDR_W-1:0] addr;
    logic                  write;
    logic [APB_DATA_W-1:0] wdata;
    logic                  unal;
  } apb_req_t;

  function automatic logic is_unaligned(
    input logic [APB_ADDR_W-1:0] a
  );
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/apb_slv_regfile.sv
// DEPTH x 32 flop array, async clear, one write port
// and one combinational read port.
module apb_slv_regfile
  import apb_slv_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [AW-1:0]         widx,
  input  logic [APB_DATA_W-1:0] wdata,
  input  logic [AW-1:0]         ridx,
  output logic [APB_DATA_W-1:0] rdata
);

  logic [APB_DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer: phase-tracking FSM, registered read data,
// saturating protocol-error counter over a word regfile.
module apb_slave_mem
  import apb_slv_pkg::*;
#(
  parameter int SLAVE_ID = 0,
  parameter int DEPTH    = 16
) (
  input  logic                  clk,
  input  logic                  Prstn,
  input  logic [NUM_PSEL-1:0]   Psel,
  input  logic                  Penable,
  input  logic                  Pwrite,
  input  logic [APB_ADDR_W-1:0] Paddr,
  input  logic [APB_DATA_W-1:0] Pwdata,
  output logic [APB_DATA_W-1:0] Prdata,
  output logic [ERR_CNT_W-1:0]  err_cnt
);

  localparam int AW = $clog2(DEPTH);

  apb_state_e state;
  apb_req_t   lat;

  logic                  sel;
  logic                  unused_psel;
  logic [AW-1:0]         idx;
  logic [APB_DATA_W-1:0] rd;
  logic                  same;
  logic                  go_setup;
  logic                  go_access;
  logic                  err;
  logic                  we;
  apb_state_e            nxt;

  assign sel         = Psel[SLAVE_ID];
  assign unused_psel = ^Psel;
  assign idx         = Paddr[2 +: AW];

  assign same = (Paddr == lat.addr)
             && (Pwrite == lat.write)
             && (Pwdata == lat.wdata);

  always_comb begin
    go_setup  = 1'b0;
    go_access = 1'b0;
    err       = 1'b0;
    nxt       = IDLE;
    unique case (state)
      SETUP: begin
        unique case (1'b1)
          (sel && Penable && same): begin
            go_access = 1'b1;
            nxt       = ACCESS;
          end
          (sel && Penable && !same): begin
            err = 1'b1;
          end
          (sel && !Penable): begin
            err      = 1'b1;
            go_setup = 1'b1;
            nxt      = SETUP;
          end
          default: begin
            err = 1'b1;
          end
        endcase
      end
      ACCESS: begin
        unique case (1'b1)
          (sel && !Penable): begin
            go_setup = 1'b1;
            nxt      = SETUP;
          end
          (sel && Penable): begin
            err = 1'b1;
          end
          default: begin
          end
        endcase
      end
      default: begin
        unique case (1'b1)
          (sel && !Penable): begin
            go_setup = 1'b1;
            nxt      = SETUP;
          end
          (sel && Penable): begin
            err = 1'b1;
          end
          default: begin
          end
        endcase
      end
    endcase
    // A misaligned setup is flagged once, even on an erroring re-setup
    if (go_setup && is_unaligned(Paddr)) begin
      err = 1'b1;
    end
  end

  assign we = go_access && lat.write && !lat.unal;

  apb_slv_regfile #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_rf (
    .clk   (clk),
    .rst_n (Prstn),
    .we    (we),
    .widx  (idx),
    .wdata (Pwdata),
    .ridx  (idx),
    .rdata (rd)
  );

  always_ff @(posedge clk or negedge Prstn) begin
    if (!Prstn) begin
      state   <= IDLE;
      lat     <= '0;
      Prdata  <= '0;
      err_cnt <= '0;
    end else begin
      state <= nxt;
      if (go_setup) begin
        lat.addr  <= Paddr;
        lat.write <= Pwrite;
        lat.wdata <= Pwdata;
        lat.unal  <= is_unaligned(Paddr);
        if (!Pwrite) begin
          Prdata <= is_unaligned(Paddr) ? '0 : rd;
        end
      end
      if (err && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: reads, writes,
// foreign select, protocol errors, saturation, reset abort.
module tb_apb_slave_mem;
  import apb_slv_pkg::*;

  logic        clk;
  logic        Prstn;
  logic [3:0]  Psel;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  apb_slave_mem #(
    .SLAVE_ID (0),
    .DEPTH    (16)
  ) dut (
    .clk     (clk),
    .Prstn   (Prstn),
    .Psel    (Psel),
    .Penable (Penable),
    .Pwrite  (Pwrite),
    .Paddr   (Paddr),
    .Pwdata  (Pwdata),
    .Prdata  (Prdata),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    Psel    = 4'b0000;
    Penable = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the access edge.
  task automatic xfer(
    input logic [3:0]  ps,
    input logic        wr,
    input logic [31:0] a,
    input logic [31:0] d
  );
    Psel    = ps;
    Penable = 1'b0;
    Pwrite  = wr;
    Paddr   = a;
    Pwdata  = d;
    @(negedge clk);
    Penable = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    Prstn   = 1'b0;
    Psel    = 4'b0000;
    Penable = 1'b0;
    Pwrite  = 1'b0;
    Paddr   = '0;
    Pwdata  = '0;
    repeat (2) @(negedge clk);
    chk("rst_prdata", Prdata, 32'h0);
    chk("rst_err", {24'h0, err_cnt}, 32'h0);
    Prstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      xfer(4'b0001, 1'b0, 32'(i * 4), 32'h0);
      chk($sformatf("rd0_w%0d", i), Prdata, 32'h0);
    end
    idle();
    chk("rd0_err", {24'h0, err_cnt}, 32'h0);

    xfer(4'b0001, 1'b1, 32'h08, 32'hDEADBEEF);
    xfer(4'b0001, 1'b0, 32'h08, 32'hDEADBEEF);
    chk("b2b_rd", Prdata, 32'hDEADBEEF);
    idle();

    xfer(4'b0010, 1'b1, 32'h00, 32'h1234);
    idle();
    xfer(4'b0001, 1'b0, 32'h00, 32'h0);
    chk("foreign_mem0", Prdata, 32'h0);
    chk("foreign_err", {24'h0, err_cnt}, 32'h0);
    idle();

    Psel    = 4'b0001;
    Penable = 1'b1;
    Pwrite  = 1'b0;
    Paddr   = 32'h0;
    @(negedge clk);
    idle();
    chk("en_no_setup", {24'h0, err_cnt}, 32'h1);

    Psel    = 4'b0001;
    Penable = 1'b0;
    Pwrite  = 1'b1;
    Paddr   = 32'h04;
    Pwdata  = 32'hCAFEF00D;
    @(negedge clk);
    Penable = 1'b1;
    Paddr   = 32'h0C;
    @(negedge clk);
    idle();
    chk("addr_chg_err", {24'h0, err_cnt}, 32'h2);
    xfer(4'b0001, 1'b0, 32'h04, 32'h0);
    chk("addr_chg_w1", Prdata, 32'h0);
    xfer(4'b0001, 1'b0, 32'h0C, 32'h0);
    chk("addr_chg_w3", Prdata, 32'h0);
    idle();

    xfer(4'b0001, 1'b1, 32'h04, 32'h11111111);
    xfer(4'b0001, 1'b0, 32'h04, 32'h0);
    chk("w1_rd", Prdata, 32'h11111111);
    xfer(4'b0001, 1'b0, 32'h05, 32'h0);
    chk("unal_rd", Prdata, 32'h0);
    chk("unal_rd_err", {24'h0, err_cnt}, 32'h3);
    xfer(4'b0001, 1'b1, 32'h06, 32'h22222222);
    chk("unal_wr_err", {24'h0, err_cnt}, 32'h4);
    xfer(4'b0001, 1'b0, 32'h04, 32'h0);
    chk("unal_wr_nocommit", Prdata, 32'h11111111);
    idle();

    Psel    = 4'b0001;
    Penable = 1'b1;
    repeat (300) @(negedge clk);
    chk("sat_255", {24'h0, err_cnt}, 32'hFF);
    @(negedge clk);
    chk("sat_hold", {24'h0, err_cnt}, 32'hFF);
    idle();
    chk("sat_idle", {24'h0, err_cnt}, 32'hFF);

    xfer(4'b0001, 1'b0, 32'h04, 32'h0);
    chk("pre_rst_rd", Prdata, 32'h11111111);
    Psel    = 4'b0001;
    Penable = 1'b0;
    Pwrite  = 1'b1;
    Paddr   = 32'h10;
    Pwdata  = 32'hA5A5A5A5;
    @(negedge clk);
    Penable = 1'b1;
    #2 Prstn = 1'b0;
    #1;
    chk("abort_prdata", Prdata, 32'h0);
    chk("abort_err", {24'h0, err_cnt}, 32'h0);
    chk("abort_state", {30'h0, dut.state}, {30'h0, IDLE});
    @(negedge clk);
    Psel    = 4'b0000;
    Penable = 1'b0;
    Prstn   = 1'b1;
    @(negedge clk);
    xfer(4'b0001, 1'b0, 32'h10, 32'h0);
    chk("abort_w4", Prdata, 32'h0);
    xfer(4'b0001, 1'b0, 32'h08, 32'h0);
    chk("rst_clr_w2", Prdata, 32'h0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB completer at the far end of the AHB-to-APB bridge: a word-addressed register bank that answers one of the bridge's four `Psel` lines. It tracks APB phases with a small FSM, commits writes in the access phase, returns registered read data, and counts protocol violations. It serves both as the RTL peripheral behind the bridge and as a reference responder for bridge verification.

## Interface
Parameters:
- `SLAVE_ID`, 0, which `Psel` bit (0..3) selects this block
- `DEPTH`, 16, number of 32-bit words (power of two, 2..256); `AW = $clog2(DEPTH)`

Ports:
- `clk`  in  1  single clock, rising edge
- `Prstn`  in  1  asynchronous, active-low reset
- `Psel`  in  4  one-hot peripheral select from bridge
- `Penable`  in  1  access-phase strobe
- `Pwrite`  in  1  1 = write, 0 = read
- `Paddr`  in  32  byte address; word index = `Paddr[2 +: AW]`, upper bits ignored
- `Pwdata`  in  32  write data
- `Prdata`  out  32  registered read data
- `err_cnt`  out  8  saturating protocol-error count

## Operation
- `sel = Psel[SLAVE_ID]`. All other `Psel` bits are ignored.
- FSM states: IDLE, SETUP, ACCESS. The state register reflects the phase sampled at the last edge.
- From IDLE:
  - `sel & !Penable` → SETUP. Latch `Paddr`, `Pwrite` and `Pwdata`. On a read, load `Prdata <= mem[idx]`.
  - `sel & Penable` → error; stay in IDLE.
  - otherwise stay in IDLE.
- From SETUP:
  - `sel & Penable` with `Paddr`, `Pwrite` and `Pwdata` equal to the latched values → ACCESS. On a write, `mem[idx] <= Pwdata`.
  - same condition with any of those fields changed → error, no commit, → IDLE.
  - `sel & !Penable` → error; re-latch as a new SETUP.
  - `!sel` → error, → IDLE.
- From ACCESS:
  - `sel & !Penable` → SETUP (back-to-back transfer; latch as from IDLE).
  - `!sel` → IDLE.
  - `sel & Penable` → error (enable held), → IDLE.
- Unaligned address (`Paddr[1:0] != 0`), checked at SETUP:
  - error.
  - A read loads `Prdata <= 0`.
  - A write that completes the access is not committed.
  - FSM proceeds normally.
- `err_cnt` increments by exactly 1 per erroring edge and saturates at 255. An unaligned access counts once, at SETUP.
- `Prdata` holds its value between reads. Writes never change `Prdata`.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): state IDLE, `Prdata` = 0, `err_cnt` = 0, all `mem` words = 0. Reset asserted mid-transfer aborts it with no commit.
- Read latency: `Prdata` is valid from the edge that samples SETUP and stable through the ACCESS cycle. The bridge samples it at the end of access.
- Write: `mem` is updated at the edge that samples ACCESS. A read whose SETUP is sampled at any later edge sees the new value.
- There are no wait states: every transfer is exactly 2 cycles, and back-to-back transfers run at 2 cycles each.

## Structure
- Package `apb_slv_pkg`:
  - `typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e`
  - `APB_ADDR_W = 32`, `APB_DATA_W = 32`, `NUM_PSEL = 4`, `ERR_CNT_W = 8`
- Sub-module `apb_slv_regfile`: `DEPTH`×32 flop array with async clear, one write port (`we`, `widx`, `wdata`) and one combinational read port (`ridx` → `rdata`).
- The top level holds the FSM, phase checks, latches, `Prdata` register and error counter.

## Test plan
- Reset, then read every word → `Prdata` = 0 on every read, `err_cnt` = 0.
- Write `0xDEADBEEF` to `0x08`, then read `0x08` back-to-back (SETUP immediately after ACCESS) → `Prdata = 0xDEADBEEF` in the read's ACCESS cycle; 4 cycles total.
- Transfer with `Psel` on another bit (`SLAVE_ID` = 0, `Psel = 4'b0010`), write `0x1234` to `0x00` → `mem[0]` stays 0, `err_cnt` stays 0.
- Protocol errors:
  - `Penable` high without a prior setup → `err_cnt` = 1.
  - Setup write to `0x04`, then `Paddr` changes to `0x0C` in access → `err_cnt` = 2, neither word written.
  - Unaligned read of `0x05` → `Prdata` = 0, `err_cnt` = 3.
- Force 300 errors → `err_cnt` = 255, held.
- Assert `Prstn` between SETUP and ACCESS of a write of `0xA5A5A5A5` to `0x10` → word 4 reads 0 after reset, FSM in IDLE, `Prdata` = 0.
